// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I/RV32E decode definitions: major opcodes, ALU operation and
// immediate-format enums, memory access size, and the decoded control bundle
// carried from decode to execute (everything except the pc).
// Helpers:
//   gen_imm  - sign-extended immediate for a given instruction format
//   base_alu - ALU operation selected by funct3 for OP / OP-IMM
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN_C = 32;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_a;   // 0 = rs1, 1 = pc
    logic        alu_src_b;   // 0 = rs2, 1 = imm
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic [2:0]  branch_cond;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr,
                                          input imm_type_e   imm_type);
    logic [31:0] imm;
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // funct3 -> ALU op shared by OP and OP-IMM; 'arith' (instr[30]) only
  // matters for the right shift. SUB is resolved by the caller.
  function automatic alu_op_e base_alu(input logic [2:0] funct3,
                                       input logic       arith);
    alu_op_e op;
    case (funct3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = arith ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// ---------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32I/RV32E instruction decoder.
// Ports:
//   instruction  in   32-bit raw instruction word
//   decoded      out  decoded_t control/operand bundle
// Register indices are reported only for fields the format actually uses
// (unused ones read 0). Any illegal encoding yields an all-zero bundle with
// only 'illegal' set, so no side-effecting control can leak through.
// ---------------------------------------------------------------------------
module decode_comb
  import rv32i_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [31:0] instruction,
  output decoded_t    decoded
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];

  logic      use_rs1;
  logic      use_rs2;
  logic      use_rd;
  logic      illegal;
  imm_type_e imm_type;
  decoded_t  d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statements can leave one unassigned (no latches).
    d        = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    illegal  = 1'b0;
    imm_type = IMM_NONE;

    case (opcode)
      OPC_LUI: begin
        use_rd      = 1'b1;
        imm_type    = IMM_U;
        d.alu_op    = ALU_PASSB;
        d.alu_src_b = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd      = 1'b1;
        imm_type    = IMM_U;
        d.alu_op    = ALU_ADD;
        d.alu_src_a = 1'b1;
        d.alu_src_b = 1'b1;
      end
      OPC_JAL: begin
        use_rd      = 1'b1;
        imm_type    = IMM_J;
        d.alu_src_a = 1'b1;
        d.alu_src_b = 1'b1;
        d.jump      = 1'b1;
      end
      OPC_JALR: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        imm_type    = IMM_I;
        d.alu_src_b = 1'b1;
        d.jump      = 1'b1;
        d.jalr      = 1'b1;
        illegal     = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        imm_type      = IMM_B;
        d.alu_op      = ALU_SUB;
        d.branch      = 1'b1;
        d.branch_cond = funct3;
        illegal       = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        use_rs1        = 1'b1;
        use_rd         = 1'b1;
        imm_type       = IMM_I;
        d.alu_src_b    = 1'b1;
        d.mem_read     = 1'b1;
        d.mem_size     = mem_size_e'(funct3[1:0]);
        d.mem_unsigned = funct3[2];
        illegal        = (funct3[1:0] == 2'd3) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        imm_type    = IMM_S;
        d.alu_src_b = 1'b1;
        d.mem_write = 1'b1;
        d.mem_size  = mem_size_e'(funct3[1:0]);
        illegal     = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        imm_type    = IMM_I;
        d.alu_src_b = 1'b1;
        d.alu_op    = base_alu(funct3, instruction[30]);
        // Shift-immediates carry a funct7 in the upper immediate bits.
        if ((funct3 == 3'd1 || funct3 == 3'd5) &&
            funct7 != 7'h00 && funct7 != 7'h20)
          illegal = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        case (funct7)
          7'h00: d.alu_op = base_alu(funct3, 1'b0);
          7'h20: begin
            if (funct3 == 3'd0)      d.alu_op = ALU_SUB;
            else if (funct3 == 3'd5) d.alu_op = ALU_SRA;
            else                     illegal  = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        // FENCE is a NOP for an in-order core without caches.
      end
      OPC_SYSTEM: begin
        illegal = (instruction != INSTR_ECALL) && (instruction != INSTR_EBREAK);
      end
      default: illegal = 1'b1;
    endcase

    // Covers compressed encodings and the all-zero word.
    if (instruction[1:0] != 2'b11) illegal = 1'b1;

    if (RV32E && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])))
      illegal = 1'b1;

    d.rs1_addr = use_rs1 ? rs1 : 5'd0;
    d.rs2_addr = use_rs2 ? rs2 : 5'd0;
    d.rd_addr  = use_rd  ? rd  : 5'd0;
    d.rd_we    = use_rd && (rd != 5'd0);
    d.imm      = gen_imm(instruction, imm_type);

    if (illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end

    decoded = d;
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I/RV32E decode stage between fetch and execute.
// One instruction + pc accepted per instr_valid_i/instr_ready_o transfer;
// the decoded bundle appears registered on the following cycle and is held
// bit-stable while out_valid_o & !out_ready_i.
// Parameters:
//   XLEN   datapath width of pc/imm (only 32 is meaningful)
//   RV32E  1 = 16-entry register file, indices >= 16 are illegal
//   SKID   1 = output + skid register, registered ready (full throughput)
//          0 = single output register, combinational ready
// Ports:
//   clk_i, rst_i (async, active high), flush_i
//   instr_valid_i / instr_ready_o, instruction_i, pc_i     fetch side
//   out_valid_o / out_ready_i, pc_o and bundle outputs     execute side
// ---------------------------------------------------------------------------
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter bit RV32E = 1'b0,
  parameter bit SKID  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_a_o,
  output logic            alu_src_b_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic            branch_o,
  output logic [2:0]      branch_cond_o,
  output logic            jump_o,
  output logic            jalr_o,
  output logic            illegal_o
);

  decoded_t        dec;
  decoded_t        out_q;
  logic [XLEN-1:0] out_pc_q;
  logic            out_valid_q;
  logic            ready;
  logic            accept;

  decode_comb #(.RV32E(RV32E)) u_decode (
    .instruction (instruction_i),
    .decoded     (dec)
  );

  assign accept = instr_valid_i & ready;

  generate
    if (SKID) begin : g_skid
      decoded_t        skid_q;
      logic [XLEN-1:0] skid_pc_q;
      logic            skid_valid_q;
      logic            ready_q;

      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          out_valid_q  <= 1'b0;
          out_q        <= '0;
          out_pc_q     <= '0;
          skid_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end else if (flush_i) begin
          // Flush wins over a simultaneous accept: that instruction is dropped.
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end else if (!out_valid_q || out_ready_i) begin
          if (skid_valid_q) begin
            // ready_q is low while the skid is full, so nothing is accepted.
            out_valid_q  <= 1'b1;
            out_q        <= skid_q;
            out_pc_q     <= skid_pc_q;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            out_valid_q <= accept;
            if (accept) begin
              out_q    <= dec;
              out_pc_q <= pc_i;
            end
          end
        end else if (accept) begin
          // Output stalled: park the new bundle and close the input.
          skid_valid_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      end

      // NOTE: skid payload has no reset; it is only ever observed behind
      // skid_valid_q, which is reset.
      always_ff @(posedge clk_i) begin
        if (!flush_i && out_valid_q && !out_ready_i && accept) begin
          skid_q    <= dec;
          skid_pc_q <= pc_i;
        end
      end

      assign ready = ready_q;
    end else begin : g_no_skid
      assign ready = !out_valid_q || out_ready_i;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
          out_pc_q    <= '0;
        end else if (flush_i) begin
          out_valid_q <= 1'b0;
        end else if (ready) begin
          out_valid_q <= instr_valid_i;
          if (accept) begin
            out_q    <= dec;
            out_pc_q <= pc_i;
          end
        end
      end
    end
  endgenerate

  assign instr_ready_o  = ready;
  assign out_valid_o    = out_valid_q;
  assign pc_o           = out_pc_q;
  assign rs1_addr_o     = out_q.rs1_addr;
  assign rs2_addr_o     = out_q.rs2_addr;
  assign rd_addr_o      = out_q.rd_addr;
  assign rd_we_o        = out_q.rd_we;
  assign imm_o          = out_q.imm;
  assign alu_op_o       = out_q.alu_op;
  assign alu_src_a_o    = out_q.alu_src_a;
  assign alu_src_b_o    = out_q.alu_src_b;
  assign mem_read_o     = out_q.mem_read;
  assign mem_write_o    = out_q.mem_write;
  assign mem_size_o     = out_q.mem_size;
  assign mem_unsigned_o = out_q.mem_unsigned;
  assign branch_o       = out_q.branch;
  assign branch_cond_o  = out_q.branch_cond;
  assign jump_o         = out_q.jump;
  assign jalr_o         = out_q.jalr;
  assign illegal_o      = out_q.illegal;

endmodule
